// File: rtl/musa_mem_pkg.sv
// Shared definitions for the MUSA core data-memory responder.
//   - Default data and word-address widths.
//   - Wait-state counter width (covers 0..15 wait states).
//   - Responder FSM state type.
package musa_mem_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with a registered read port.
//   clk_i    : clock, rising edge
//   rst_ni   : async active-low reset (clears only the read register, not storage)
//   en_i     : access enable for this edge
//   we_i     : 1 = write wdata_i, 0 = load rdata_o from storage
//   addr_i   : word address, must be < DEPTH when en_i is high
//   wdata_i  : write data
//   rdata_o  : read register; updated only by enabled reads, held otherwise
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MUSA core load/store port. Captures a request,
// waits WAIT_CYCLES, accesses the word array, and returns a one-cycle ack.
//   clk    : clock, rising edge
//   rst_n  : async active-low reset; drops any in-flight request
//   req    : request valid, held by initiator until ack
//   we     : 1 = write, 0 = read
//   addr   : word address (>= DEPTH is out of range)
//   wdata  : write data
//   rdata  : read data, valid with ack, held until the next read response
//   ack    : one-cycle response pulse
//   err    : out-of-range flag, valid with ack
//   busy   : high whenever the FSM is not idle
module dmem_responder
  import musa_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oor_q, oor_d;
  // Last read response was out of range: present zero instead of the RAM register.
  logic              rdz_q, rdz_d;

  logic              addr_oor;
  logic              acc;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_oor;
  logic [DATA_W-1:0] arr_rdata;

  assign addr_oor = (32'(addr) >= DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    rdz_d   = rdz_q;
    acc     = 1'b0;
    a_we    = we_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_oor   = oor_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          oor_d   = addr_oor;
          cnt_d   = CNT_INIT;
          if (WAIT_CYCLES == 0) begin
            // Capture and access share one edge, so the array sees the live inputs.
            state_d = RESP;
            acc     = 1'b1;
            a_we    = we;
            a_addr  = addr;
            a_wdata = wdata;
            a_oor   = addr_oor;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          acc     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (acc && !a_we) begin
      rdz_d = a_oor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rdz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      rdz_q   <= rdz_d;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (acc && !a_oor),
    .we_i    (a_we),
    .addr_i  (a_addr),
    .wdata_i (a_wdata),
    .rdata_o (arr_rdata)
  );

  assign ack   = (state_q == RESP);
  assign err   = (state_q == RESP) && oor_q;
  assign busy  = (state_q != IDLE);
  assign rdata = rdz_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Instance 0: WAIT_CYCLES=2, DEPTH=1000.
// Instance 1: WAIT_CYCLES=0, DEPTH=1024. Expected responses (owning instance,
// ack cycle, err, rdata) are queued by the stimulus and checked by a monitor.
module tb_dmem_responder;

  typedef struct {
    int          dut;
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [9:0]  addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ack_s   [2];
  logic        err_s   [2];
  logic        busy_s  [2];

  exp_t        sbq[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          wc[2] = '{2, 0};
  logic [31:0] last_rd[2];

  dmem_responder #(
    .DATA_W      (32),
    .ADDR_W      (10),
    .DEPTH       (1000),
    .WAIT_CYCLES (2)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_s[0]),
    .we    (we_s[0]),
    .addr  (addr_s[0]),
    .wdata (wdata_s[0]),
    .rdata (rdata_s[0]),
    .ack   (ack_s[0]),
    .err   (err_s[0]),
    .busy  (busy_s[0])
  );

  dmem_responder #(
    .DATA_W      (32),
    .ADDR_W      (10),
    .DEPTH       (1024),
    .WAIT_CYCLES (0)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_s[1]),
    .we    (we_s[1]),
    .addr  (addr_s[1]),
    .wdata (wdata_s[1]),
    .rdata (rdata_s[1]),
    .ack   (ack_s[1]),
    .err   (err_s[1]),
    .busy  (busy_s[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n && ack_s[d]) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ack dut%0d cycle %0d err %0b rdata %h", d, cyc, err_s[d], rdata_s[d]);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_e.dut != d || mon_e.cyc != cyc || err_s[d] !== mon_e.err || rdata_s[d] !== mon_e.rdata) begin
            miscompares++;
            $display("FAIL ack_resp: got dut%0d cycle %0d err %0b rdata %h, exp dut%0d cycle %0d err %0b rdata %h",
                     d, cyc, err_s[d], rdata_s[d], mon_e.dut, mon_e.cyc, mon_e.err, mon_e.rdata);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h exp %h", name, got, exp);
    end
  endtask

  // One request; churn scrambles the inputs in the cycle after capture.
  task automatic req_one(input int d, input logic w, input logic [9:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd, input bit churn);
    exp_t e;
    bit   got;
    @(negedge clk);
    req_s[d]   = 1'b1;
    we_s[d]    = w;
    addr_s[d]  = a;
    wdata_s[d] = wd;
    e.dut   = d;
    e.cyc   = cyc + 1 + wc[d];
    e.err   = e_err;
    e.rdata = w ? last_rd[d] : e_rd;
    last_rd[d] = e.rdata;
    sbq.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (churn && k == 0) begin
        we_s[d]    = ~w;
        addr_s[d]  = a + 10'd1;
        wdata_s[d] = ~wd;
      end
      if (ack_s[d]) got = 1'b1;
    end
    req_s[d] = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout dut%0d addr %0d: got no ack, exp ack within 40 cycles", d, a);
    end
  endtask

  initial begin
    int n;
    int d0;
    for (int d = 0; d < 2; d++) begin
      req_s[d]   = 1'b0;
      we_s[d]    = 1'b0;
      addr_s[d]  = '0;
      wdata_s[d] = '0;
      last_rd[d] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_rdata", rdata_s[d], 32'h0);
      check("reset_ack",   32'(ack_s[d]), 32'h0);
      check("reset_err",   32'(err_s[d]), 32'h0);
      check("reset_busy",  32'(busy_s[d]), 32'h0);
    end
    rst_n = 1'b1;

    // Reset mid-WAIT discards the write
    req_one(0, 1'b1, 10'd5, 32'h0000_5555, 1'b0, 32'h0, 1'b0);
    req_one(0, 1'b0, 10'd5, 32'h0, 1'b0, 32'h0000_5555, 1'b0);
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 10'd5; wdata_s[0] = 32'h0000_0BAD;
    @(negedge clk);
    check("midwait_busy", 32'(busy_s[0]), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_ack",   32'(ack_s[0]), 32'h0);
    check("rst_err",   32'(err_s[0]), 32'h0);
    check("rst_busy",  32'(busy_s[0]), 32'h0);
    check("rst_rdata", rdata_s[0], 32'h0);
    req_s[0] = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy_s[0]), 32'h0);
    req_one(0, 1'b0, 10'd5, 32'h0, 1'b0, 32'h0000_5555, 1'b0);

    // Write/read with WAIT_CYCLES=2, rdata holds after ack
    req_one(0, 1'b1, 10'd3, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    req_one(0, 1'b0, 10'd3, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rdata_hold", rdata_s[0], 32'hDEAD_BEEF);
      check("ack_low_after", 32'(ack_s[0]), 32'h0);
    end

    // Out of range with DEPTH=1000
    req_one(0, 1'b1, 10'd999,  32'h0000_0999, 1'b0, 32'h0, 1'b0);
    req_one(0, 1'b0, 10'd999,  32'h0, 1'b0, 32'h0000_0999, 1'b0);
    req_one(0, 1'b1, 10'd1000, 32'h0000_1000, 1'b1, 32'h0, 1'b0);
    req_one(0, 1'b0, 10'd1000, 32'h0, 1'b1, 32'h0, 1'b0);
    req_one(0, 1'b0, 10'd999,  32'h0, 1'b0, 32'h0000_0999, 1'b0);

    // Input churn during WAIT
    req_one(0, 1'b1, 10'd8, 32'h0000_0088, 1'b0, 32'h0, 1'b0);
    req_one(0, 1'b1, 10'd7, 32'h0000_0011, 1'b0, 32'h0, 1'b1);
    req_one(0, 1'b0, 10'd7, 32'h0, 1'b0, 32'h0000_0011, 1'b0);
    req_one(0, 1'b0, 10'd8, 32'h0, 1'b0, 32'h0000_0088, 1'b0);

    // rdata hold across a write response
    req_one(0, 1'b1, 10'd3, 32'h0000_00A5, 1'b0, 32'h0, 1'b0);
    req_one(0, 1'b0, 10'd3, 32'h0, 1'b0, 32'h0000_00A5, 1'b0);
    req_one(0, 1'b1, 10'd4, 32'h0000_0044, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("rdata_after_write", rdata_s[0], 32'h0000_00A5);

    // WAIT_CYCLES=0 back-to-back reads
    req_one(1, 1'b1, 10'd1, 32'h0000_0101, 1'b0, 32'h0, 1'b0);
    req_one(1, 1'b1, 10'd2, 32'h0000_0202, 1'b0, 32'h0, 1'b0);
    req_one(1, 1'b1, 10'd3, 32'h0000_0303, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    d0 = cyc;
    req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 10'd1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.dut   = 1;
      e.cyc   = d0 + 1 + 2 * i;
      e.err   = 1'b0;
      e.rdata = 32'h0000_0101 * (i + 1);
      sbq.push_back(e);
    end
    last_rd[1] = 32'h0000_0303;
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("b2b_busy", 32'(busy_s[1]), (k % 2 == 1) ? 32'h1 : 32'h0);
      if (ack_s[1]) begin
        n++;
        if (n < 3) addr_s[1] = 10'(n + 1);
        else req_s[1] = 1'b0;
      end
    end
    req_s[1] = 1'b0;
    check("b2b_ack_count", 32'(n), 32'd3);

    // Nothing left outstanding
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
